// File: rtl/reg_dbg_pkg.sv
// Shared types and constants for the register-file debug readout path.
package reg_dbg_pkg;

    localparam int unsigned NUM_REGS  = 32;
    localparam int unsigned REG_IDX_W = 5;

    typedef logic [REG_IDX_W-1:0] reg_idx_t;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        SEND,
        DONE
    } dump_state_t;

endpackage

// File: rtl/reg_file_dump.sv
// Debug readout engine: walks registers first..last through one combinational
// read port and streams value+index beats over a valid/ready handshake.
module reg_file_dump
    import reg_dbg_pkg::*;
#(
    parameter int unsigned NUM_REGS   = reg_dbg_pkg::NUM_REGS,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned IDX_WIDTH  = reg_dbg_pkg::REG_IDX_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic [IDX_WIDTH-1:0]  first_reg,
    input  logic [IDX_WIDTH-1:0]  last_reg,
    output logic [IDX_WIDTH-1:0]  rd_reg,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [IDX_WIDTH-1:0]  out_idx,
    output logic                  out_last,
    output logic                  busy,
    output logic                  done,
    output logic                  range_err
);

    localparam logic [IDX_WIDTH-1:0] MAX_IDX = IDX_WIDTH'(NUM_REGS - 1);

    dump_state_t          state;
    logic [IDX_WIDTH-1:0] idx;
    logic [IDX_WIDTH-1:0] last;

    // The read index simply follows the walk counter in every state.
    assign rd_reg = idx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= '0;
            last      <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_idx   <= '0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            range_err <= 1'b0;
        end else begin
            done      <= 1'b0;
            range_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !abort) begin
                        if (first_reg <= last_reg) begin
                            idx   <= first_reg;
                            last  <= last_reg;
                            busy  <= 1'b1;
                            state <= READ;
                        end else begin
                            range_err <= 1'b1;
                        end
                    end
                end
                READ: begin
                    if (abort) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end else begin
                        out_data  <= rd_data;
                        out_idx   <= idx;
                        // MAX_IDX term keeps the counter from ever wrapping.
                        out_last  <= (idx == last) || (idx == MAX_IDX);
                        out_valid <= 1'b1;
                        state     <= SEND;
                    end
                end
                SEND: begin
                    if (abort) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        if (out_last) begin
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            idx   <= idx + 1'b1;
                            state <= READ;
                        end
                    end
                end
                DONE: begin
                    out_last <= 1'b0;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
